// File: rtl/seg_scan_display.sv
// rtl/seg_scan_display.sv - eight-tube 7-segment scanner with frame latch, leading-zero blanking and blink
module seg_scan_display #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLINK_DIV = 50000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] time_data,
  input  logic        lz_en,
  input  logic [7:0]  blink_mask,
  output logic [7:0]  digit1,
  output logic [7:0]  digit2,
  output logic [7:0]  tube_sel
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [SW-1:0] scan_cnt;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  logic [1:0]    idx;
  logic [31:0]   frame;

  logic          tick;
  logic          blink_wrap;
  logic [1:0]    idx_nxt;
  logic [31:0]   src;
  logic [3:0]    nib [8];
  logic [7:0]    blank_lz;
  logic          zrun;
  logic [2:0]    tube_a;
  logic [2:0]    tube_b;
  logic [7:0]    seg_a;
  logic [7:0]    seg_b;
  logic [7:0]    sel_nxt;

  // Nibble to {a,b,c,d,e,f,g,dp}; F is a dash, A..E blank.
  function automatic logic [7:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: seg_of = 8'hFC;
      4'h1: seg_of = 8'h60;
      4'h2: seg_of = 8'hDA;
      4'h3: seg_of = 8'hF2;
      4'h4: seg_of = 8'h66;
      4'h5: seg_of = 8'hB6;
      4'h6: seg_of = 8'hBE;
      4'h7: seg_of = 8'hE0;
      4'h8: seg_of = 8'hFE;
      4'h9: seg_of = 8'hF6;
      4'hF: seg_of = 8'h02;
      default: seg_of = 8'h00;
    endcase
  endfunction

  assign tick       = (scan_cnt == SCAN_LAST);
  assign blink_wrap = (blink_cnt == BLINK_LAST);

  // Next scan position's segments; the frame-start position reads time_data directly so it matches what gets latched.
  always_comb begin
    idx_nxt  = idx + 2'd1;
    src      = (idx_nxt == 2'd0) ? time_data : frame;
    zrun     = 1'b1;
    blank_lz = 8'h00;
    for (int i = 0; i < 8; i++) begin
      nib[i]      = src[31-4*i -: 4];
      zrun        = zrun & (nib[i] == 4'h0);
      blank_lz[i] = lz_en & zrun & (i != 7);
    end
    tube_a = {1'b0, idx_nxt};
    tube_b = {1'b1, idx_nxt};
    seg_a  = seg_of(nib[tube_a]);
    seg_b  = seg_of(nib[tube_b]);
    if (blank_lz[tube_a] || (!blink_phase && blink_mask[3'd7 - tube_a])) seg_a = 8'h00;
    if (blank_lz[tube_b] || (!blink_phase && blink_mask[3'd7 - tube_b])) seg_b = 8'h00;
    sel_nxt = (8'b1000_0000 >> idx_nxt) | (8'b0000_1000 >> idx_nxt);
  end

  // Scan-rate counter, scan position and frame latch at the start of each frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      idx      <= 2'd3;
      frame    <= 32'h0;
    end else begin
      scan_cnt <= tick ? '0 : scan_cnt + 1'b1;
      if (tick) begin
        idx <= idx_nxt;
        if (idx_nxt == 2'd0) frame <= time_data;
      end
    end
  end

  // Free-running blink timer; phase starts visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else begin
      blink_cnt <= blink_wrap ? '0 : blink_cnt + 1'b1;
      if (blink_wrap) blink_phase <= ~blink_phase;
    end
  end

  // Registered tube drive, updated only on scan ticks; en=0 darkens the display.
  always_ff @(posedge clk) begin
    if (rst) begin
      digit1   <= 8'h00;
      digit2   <= 8'h00;
      tube_sel <= 8'h00;
    end else if (tick) begin
      digit1   <= en ? seg_a : 8'h00;
      digit2   <= en ? seg_b : 8'h00;
      tube_sel <= en ? sel_nxt : 8'h00;
    end
  end

endmodule
